// File: rtl/host_ahb_slave_tx.sv
// AHB-Lite slave that frames SoC-supplied length and data words into the host byte stream
// (SOF1, SOF2, LEN lo, LEN hi, payload) and pushes them one byte per clock into the tx FIFO.
module host_ahb_slave_tx #(
  parameter logic [7:0] SOF1_BYTE = 8'h55,
  parameter logic [7:0] SOF2_BYTE = 8'hAA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_ahb_hsel,
  input  logic [1:0]  s_ahb_htrans,
  input  logic        s_ahb_hwrite,
  input  logic [2:0]  s_ahb_hsize,
  input  logic [31:0] s_ahb_haddr,
  input  logic [31:0] s_ahb_hwdata,
  input  logic        s_ahb_hready,
  output logic [31:0] s_ahb_hrdata,
  output logic        s_ahb_hreadyout,
  output logic        s_ahb_hresp,
  output logic        tx_fifo_wr_en,
  output logic [7:0]  tx_fifo_dout,
  input  logic        tx_fifo_full,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SOF1, ST_SOF2, ST_LEN1, ST_LEN2, ST_DATA
  } state_t;

  localparam logic [1:0] OFF_LEN    = 2'd0;
  localparam logic [1:0] OFF_DATA   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;

  state_t      state, state_next;
  logic [15:0] len;
  logic [16:0] acc_bytes;
  logic [16:0] sent_bytes;
  logic [31:0] hold;
  logic        hold_valid;
  logic        err;

  logic        dp_valid;
  logic        dp_write;
  logic [1:0]  dp_off;

  logic        data_push;
  logic        last_byte;
  logic        hold_free;
  logic        dp_end;
  logic        len_wr;
  logic        data_wr;
  logic        status_rd;
  logic        busy;
  logic [31:0] status_word;
  logic        unused_bits;

  assign unused_bits = ^{s_ahb_hsize, s_ahb_haddr[31:4], s_ahb_haddr[1:0], s_ahb_htrans[0]};

  // NOTE: the push strobe is combinational so a full flag raised this cycle blocks this cycle's byte;
  // it is also held off while reset is asserted so an aborted frame emits nothing more.
  assign tx_fifo_wr_en = ~reset & (state != ST_IDLE) & ~tx_fifo_full
                       & ((state != ST_DATA) | hold_valid);
  assign data_push     = tx_fifo_wr_en & (state == ST_DATA);
  assign last_byte     = (sent_bytes + 17'd1) == {1'b0, len};
  assign hold_free     = data_push & ((sent_bytes[1:0] == 2'd3) | last_byte);
  assign tx_done       = tx_fifo_wr_en & (((state == ST_LEN2) & (len == 16'd0))
                                        | ((state == ST_DATA) & last_byte));

  // A DATA write waits only while the hold word is still occupied after this cycle.
  assign s_ahb_hreadyout = ~(dp_valid & dp_write & (dp_off == OFF_DATA) & hold_valid & ~hold_free);
  assign s_ahb_hresp     = 1'b0;

  assign dp_end    = dp_valid & s_ahb_hreadyout;
  assign len_wr    = dp_end & dp_write & (dp_off == OFF_LEN);
  assign data_wr   = dp_end & dp_write & (dp_off == OFF_DATA);
  assign status_rd = dp_end & ~dp_write & (dp_off == OFF_STATUS);

  assign busy         = (state != ST_IDLE);
  assign status_word  = {len - sent_bytes[15:0], 13'd0, err, hold_valid, busy};
  assign s_ahb_hrdata = (dp_valid & ~dp_write & (dp_off == OFF_STATUS)) ? status_word : 32'd0;

  always_comb begin
    tx_fifo_dout = 8'd0;
    unique case (state)
      ST_SOF1: tx_fifo_dout = SOF1_BYTE;
      ST_SOF2: tx_fifo_dout = SOF2_BYTE;
      ST_LEN1: tx_fifo_dout = len[7:0];
      ST_LEN2: tx_fifo_dout = len[15:8];
      ST_DATA: tx_fifo_dout = hold[{sent_bytes[1:0], 3'b000} +: 8];
      default: tx_fifo_dout = 8'd0;
    endcase
  end

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (len_wr)        state_next = ST_SOF1;
      ST_SOF1: if (tx_fifo_wr_en) state_next = ST_SOF2;
      ST_SOF2: if (tx_fifo_wr_en) state_next = ST_LEN1;
      ST_LEN1: if (tx_fifo_wr_en) state_next = ST_LEN2;
      ST_LEN2: if (tx_fifo_wr_en) state_next = (len == 16'd0) ? ST_IDLE : ST_DATA;
      ST_DATA: if (tx_fifo_wr_en && last_byte) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len        <= '0;
      acc_bytes  <= '0;
      sent_bytes <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      err        <= 1'b0;
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      dp_off     <= '0;
    end else begin
      if (s_ahb_hready) begin
        dp_valid <= s_ahb_hsel & s_ahb_htrans[1];
        dp_write <= s_ahb_hwrite;
        dp_off   <= s_ahb_haddr[3:2];
      end

      if (data_push) begin
        sent_bytes <= sent_bytes + 17'd1;
        if (hold_free) hold_valid <= 1'b0;
      end

      if (len_wr) begin
        if (state == ST_IDLE) begin
          len        <= s_ahb_hwdata[15:0];
          acc_bytes  <= '0;
          sent_bytes <= '0;
        end else begin
          err <= 1'b1;
        end
      end

      // A write landing as the hold word frees must win over the clear above.
      if (data_wr) begin
        if ((state == ST_IDLE) || (acc_bytes >= {1'b0, len})) begin
          err <= 1'b1;
        end else begin
          hold       <= s_ahb_hwdata;
          hold_valid <= 1'b1;
          acc_bytes  <= acc_bytes + 17'd4;
        end
      end

      if (status_rd) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_host_ahb_slave_tx.sv
// Bench for host_ahb_slave_tx: a queue model of the expected byte stream and register view,
// checked every cycle, plus directed frames with literal expectations and a randomized phase.
module tb_host_ahb_slave_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_ahb_hsel = 1'b0;
  logic [1:0]  s_ahb_htrans = 2'b00;
  logic        s_ahb_hwrite = 1'b0;
  logic [2:0]  s_ahb_hsize = 3'b010;
  logic [31:0] s_ahb_haddr = '0;
  logic [31:0] s_ahb_hwdata = '0;
  logic        s_ahb_hready;
  logic [31:0] s_ahb_hrdata;
  logic        s_ahb_hreadyout;
  logic        s_ahb_hresp;
  logic        tx_fifo_wr_en;
  logic [7:0]  tx_fifo_dout;
  logic        tx_fifo_full = 1'b0;
  logic        tx_done;

  assign s_ahb_hready = s_ahb_hreadyout;
  always #5 clk = ~clk;

  host_ahb_slave_tx dut (
    .clk            (clk),
    .reset          (reset),
    .s_ahb_hsel     (s_ahb_hsel),
    .s_ahb_htrans   (s_ahb_htrans),
    .s_ahb_hwrite   (s_ahb_hwrite),
    .s_ahb_hsize    (s_ahb_hsize),
    .s_ahb_haddr    (s_ahb_haddr),
    .s_ahb_hwdata   (s_ahb_hwdata),
    .s_ahb_hready   (s_ahb_hready),
    .s_ahb_hrdata   (s_ahb_hrdata),
    .s_ahb_hreadyout(s_ahb_hreadyout),
    .s_ahb_hresp    (s_ahb_hresp),
    .tx_fifo_wr_en  (tx_fifo_wr_en),
    .tx_fifo_dout   (tx_fifo_dout),
    .tx_fifo_full   (tx_fifo_full),
    .tx_done        (tx_done)
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  off;
    logic [31:0] data;
  } txn_t;

  typedef struct packed {
    logic       is_data;
    logic       last;
    logic [7:0] b;
  } ent_t;

  txn_t bus_q[$];
  ent_t exp_q[$];
  logic [7:0] cap_b[$];
  int         cap_c[$];

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit        m_active = 0;
  bit        m_err = 0;
  int        m_len = 0, m_acc = 0, m_sent = 0, data_rem = 0;
  bit        dp_v = 0, dp_w = 0;
  bit [1:0]  dp_off = 0;
  int        cyc = 0;
  int        stall_cnt = 0;
  int        done_cnt = 0;
  logic [7:0]  last_done_b = '0;
  logic [31:0] last_rd = '0;
  logic      rdy_s = 1'b1;

  // driver / control state
  bit   a_v = 0;
  txn_t a_t = '0;
  bit   force_full = 0;
  bit   rand_full = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: advance expected outputs and register view once per cycle.
  always @(negedge clk) begin
    ent_t        h;
    ent_t        e;
    bit          push, free, rdy;
    logic [31:0] st;
    if (tx_fifo_wr_en) begin
      cap_b.push_back(tx_fifo_dout);
      cap_c.push_back(cyc);
    end
    if (tx_done) begin
      done_cnt++;
      last_done_b = tx_fifo_dout;
    end
    if (reset) begin
      check("rst_wr_en", tx_fifo_wr_en, 0);
      check("rst_tx_done", tx_done, 0);
      check("rst_hreadyout", s_ahb_hreadyout, 1);
      check("rst_hrdata", s_ahb_hrdata, 0);
      exp_q.delete();
      m_active = 0; m_err = 0; m_len = 0; m_acc = 0; m_sent = 0; data_rem = 0;
      dp_v = 0; dp_w = 0; dp_off = 0;
    end else begin
      push = (exp_q.size() > 0) && !tx_fifo_full;
      h    = push ? exp_q[0] : '0;
      free = push && h.is_data && (data_rem == 1);
      rdy  = !(dp_v && dp_w && (dp_off == 2'd1) && (data_rem > 0) && !free);
      if (!rdy) stall_cnt++;

      check("wr_en", tx_fifo_wr_en, push);
      check("tx_done", tx_done, push && h.last);
      if (push) check("dout", tx_fifo_dout, h.b);
      check("hreadyout", s_ahb_hreadyout, rdy);
      check("hresp", s_ahb_hresp, 0);

      if (dp_v && !dp_w && rdy) begin
        st = (dp_off == 2'd2) ? {16'(m_len - m_sent), 13'd0, m_err, data_rem > 0, m_active} : 32'd0;
        check("hrdata", s_ahb_hrdata, st);
        last_rd = s_ahb_hrdata;
      end

      if (dp_v && rdy) begin
        if (dp_w && dp_off == 2'd0) begin
          if (!m_active) begin
            m_len = int'(s_ahb_hwdata[15:0]);
            m_acc = 0; m_sent = 0; m_active = 1;
            e = '{1'b0, 1'b0, 8'h55};                 exp_q.push_back(e);
            e = '{1'b0, 1'b0, 8'hAA};                 exp_q.push_back(e);
            e = '{1'b0, 1'b0, s_ahb_hwdata[7:0]};     exp_q.push_back(e);
            e = '{1'b0, m_len == 0, s_ahb_hwdata[15:8]}; exp_q.push_back(e);
          end else begin
            m_err = 1;
          end
        end else if (dp_w && dp_off == 2'd1) begin
          if (!m_active || m_acc >= m_len) begin
            m_err = 1;
          end else begin
            for (int k = 0; k < 4; k++) begin
              if (m_acc + k < m_len) begin
                e = '{1'b1, (m_acc + k) == (m_len - 1), s_ahb_hwdata[8*k +: 8]};
                exp_q.push_back(e);
                data_rem++;
              end
            end
            m_acc += 4;
          end
        end else if (!dp_w && dp_off == 2'd2) begin
          m_err = 0;
        end
      end

      if (push) begin
        void'(exp_q.pop_front());
        if (h.is_data) begin
          m_sent++;
          data_rem--;
        end
        if (h.last) m_active = 0;
      end

      if (rdy) begin
        dp_v   = s_ahb_hsel && s_ahb_htrans[1];
        dp_w   = s_ahb_hwrite;
        dp_off = s_ahb_haddr[3:2];
      end
    end
    rdy_s = s_ahb_hreadyout;
    cyc++;
  end

  // Pipelined AHB master: next address phase and current data phase advance on each ready edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rdy_s) begin
        #1;
        s_ahb_hwdata = a_t.data;
        if (bus_q.size() > 0) begin
          a_t = bus_q.pop_front();
          a_v = 1;
        end else begin
          a_v = 0;
        end
        s_ahb_hsel   = a_v;
        s_ahb_htrans = a_v ? 2'b10 : 2'b00;
        s_ahb_hwrite = a_v && a_t.wr;
        s_ahb_haddr  = {28'd0, a_t.off, 2'b00};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_fifo_full = force_full || (rand_full && ($urandom_range(0, 3) == 0));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
    $fatal(1);
  end

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    txn_t t;
    t.wr = 1'b1; t.off = off; t.data = d;
    bus_q.push_back(t);
  endtask

  task automatic rd(input logic [1:0] off);
    txn_t t;
    t.wr = 1'b0; t.off = off; t.data = $urandom;
    bus_q.push_back(t);
  endtask

  task automatic wait_bus(input string name);
    int n = 0;
    while ((a_v || bus_q.size() > 0 || dp_v) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_bus_timeout"}, n < 3000, 1);
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while ((a_v || bus_q.size() > 0 || dp_v || exp_q.size() > 0 || m_active) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_frame_timeout"}, n < 3000, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_cap(input string name, input int cnt);
    int n = 0;
    while (cap_b.size() < cnt && n < 200) begin
      @(posedge clk);
      n++;
    end
    check({name, "_cap_timeout"}, n < 200, 1);
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp_b[$]);
    check({name, "_count"}, cap_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++) check(name, cap_b[i], exp_b[i]);
  endtask

  task automatic clear_cap();
    cap_b.delete();
    cap_c.delete();
  endtask

  initial begin
    logic [7:0] e[$];
    int d0;
    int len;
    int nw;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rd(2'd2);
    wait_bus("t0");
    check("t0_status_after_reset", last_rd, 32'd0);

    // 1: five-byte frame, second word partly discarded
    clear_cap(); d0 = done_cnt;
    wr(2'd0, 32'd5); wr(2'd1, 32'h44332211); wr(2'd1, 32'h00000055);
    wait_frame("t1");
    e = '{8'h55, 8'hAA, 8'h05, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    check_bytes("t1_bytes", e);
    if (cap_c.size() == 9) check("t1_consecutive", cap_c[8] - cap_c[0], 8);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_done_byte", last_done_b, 8'h55);

    // 2: empty frame, then a stray DATA write and err read/clear
    clear_cap(); d0 = done_cnt;
    wr(2'd0, 32'd0);
    wait_frame("t2");
    e = '{8'h55, 8'hAA, 8'h00, 8'h00};
    check_bytes("t2_bytes", e);
    check("t2_done_count", done_cnt - d0, 1);
    wr(2'd1, 32'hDEADBEEF); rd(2'd2);
    wait_frame("t2b");
    check("t2_status_err", last_rd, 32'h0000_0004);
    rd(2'd2);
    wait_bus("t2c");
    check("t2_status_cleared", last_rd, 32'd0);
    check("t2_no_extra_bytes", cap_b.size(), 4);

    // 3: back-to-back DATA writes must stall on the busy hold word
    clear_cap(); stall_cnt = 0;
    wr(2'd0, 32'd12);
    wr(2'd1, 32'h03020100); wr(2'd1, 32'h07060504); wr(2'd1, 32'h0B0A0908);
    wait_frame("t3");
    e = '{8'h55, 8'hAA, 8'h0C, 8'h00};
    for (int i = 0; i < 12; i++) e.push_back(8'(i));
    check_bytes("t3_bytes", e);
    check("t3_saw_wait_state", stall_cnt > 0, 1);

    // 4: FIFO full for 10 clocks right after the LEN2 byte
    clear_cap();
    wr(2'd0, 32'd4); wr(2'd1, 32'hDDCCBBAA);
    wait_cap("t4", 4);
    force_full = 1;
    repeat (10) @(posedge clk);
    check("t4_no_push_while_full", cap_b.size(), 4);
    force_full = 0;
    wait_frame("t4");
    e = '{8'h55, 8'hAA, 8'h04, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    check_bytes("t4_bytes", e);

    // 5: LEN write mid-frame is ignored and flagged
    clear_cap();
    wr(2'd0, 32'd8); wr(2'd1, 32'h14131211);
    wait_cap("t5", 2);
    wr(2'd0, 32'd3); rd(2'd2);
    wait_bus("t5");
    check("t5_err_bit", last_rd[2], 1);
    check("t5_busy_bit", last_rd[0], 1);
    check("t5_len_field", last_rd[31:16], 16'd8);
    wr(2'd1, 32'h18171615);
    wait_frame("t5");
    e = '{8'h55, 8'hAA, 8'h08, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    check_bytes("t5_bytes", e);

    // 6: reset after two payload bytes aborts the frame; a fresh frame follows
    clear_cap(); d0 = done_cnt;
    wr(2'd0, 32'd6); wr(2'd1, 32'h44332211);
    wait_cap("t6", 6);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    check("t6_aborted_bytes", cap_b.size(), 6);
    rd(2'd2);
    wait_bus("t6");
    check("t6_status_idle", last_rd, 32'd0);
    check("t6_no_done_on_abort", done_cnt - d0, 0);
    clear_cap();
    wr(2'd0, 32'd1); wr(2'd1, 32'h000000EF);
    wait_frame("t6b");
    e = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'hEF};
    check_bytes("t6_bytes", e);
    check("t6_done_count", done_cnt - d0, 1);

    // randomized frames with random back-pressure and interleaved register traffic
    rand_full = 1;
    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(0, 24);
      wr(2'd0, {16'($urandom), 16'(len)});
      nw = (len + 3) / 4 + (($urandom_range(0, 3) == 0) ? 1 : 0);
      for (int w = 0; w < nw; w++) begin
        wr(2'd1, $urandom);
        if ($urandom_range(0, 3) == 0) rd(2'd2);
        if ($urandom_range(0, 7) == 0) rd(2'($urandom_range(0, 3)));
        if ($urandom_range(0, 7) == 0) wr(2'd3, $urandom);
      end
      rd(2'd2);
      wait_frame("rand");
    end
    rand_full = 0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
